demux_collect8: RTL and testbench

//  Inverse of the ALU 8-to-1 result mux. Takes a WIDTH-bit result stream and

---
 rtl/demux_collect8.sv | 120 ++++++++++++
 tb/tb_demux_collect8.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_collect8.sv
// demux_collect8: routes a result stream into 8 registered lanes and
// hands the completed set of lanes downstream through a valid/ready handshake.
module demux_collect8 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [2:0]       F,
    input  logic [WIDTH-1:0] D,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic [WIDTH-1:0] O4,
    output logic [WIDTH-1:0] O5,
    output logic [WIDTH-1:0] O6,
    output logic [WIDTH-1:0] O7,
    output logic [7:0]       lane_vld,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

    state_e           state_q, state_d;
    logic [7:0]       vld_q, vld_d;
    logic [2:0]       ptr_q, ptr_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] data_q [8];

    logic             wr_en;
    logic             eff_mode;
    logic [2:0]       target;

    // Next-state decode: clear wins over everything, then the bundle handshake, then writes.
    always_comb begin
        state_d  = state_q;
        vld_d    = vld_q;
        ptr_d    = ptr_q;
        mode_d   = mode_q;
        wr_en    = 1'b0;
        // The mode seen on the first write of a bundle governs the whole bundle.
        eff_mode = (state_q == StIdle) ? mode : mode_q;
        target   = eff_mode ? ptr_q : (3'd7 - F);

        if (clear) begin
            state_d = StIdle;
            vld_d   = '0;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                StFull: begin
                    if (out_ready) begin
                        state_d = StIdle;
                        vld_d   = '0;
                        ptr_d   = '0;
                    end
                end
                StIdle, StFill: begin
                    if (in_valid) begin
                        wr_en = 1'b1;
                        vld_d = vld_q | (8'b1 << target);
                        if (eff_mode) begin
                            ptr_d = ptr_q + 3'd1;
                        end
                        if (state_q == StIdle) begin
                            mode_d = mode;
                        end
                        state_d = (vld_d == 8'hFF) ? StFull : StFill;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vld_q   <= '0;
            ptr_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
        end
    end

    // Lane data registers; only reset and accepted writes change them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= '0;
            end
        end else if (wr_en) begin
            data_q[target] <= D;
        end
    end

    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q == StFull);
    assign lane_vld  = vld_q;

    assign O0 = data_q[0];
    assign O1 = data_q[1];
    assign O2 = data_q[2];
    assign O3 = data_q[3];
    assign O4 = data_q[4];
    assign O5 = data_q[5];
    assign O6 = data_q[6];
    assign O7 = data_q[7];

endmodule

// File: tb/tb_demux_collect8.sv
// Self-checking bench for demux_collect8 (WIDTH=8) with a lane model and bundle scoreboard.
module tb_demux_collect8;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mode = 1'b0;
    logic [2:0]   F = '0;
    logic [W-1:0] D = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         clear = 1'b0;
    logic [W-1:0] O0, O1, O2, O3, O4, O5, O6, O7;
    logic [7:0]   lane_vld;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [W-1:0]    m_o [8];
    logic [7:0]      m_vld;
    logic [2:0]      m_ptr;
    logic            m_mode;
    logic [8*W-1:0]  sb_q [$];

    demux_collect8 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .F         (F),
        .D         (D),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clear     (clear),
        .O0        (O0),
        .O1        (O1),
        .O2        (O2),
        .O3        (O3),
        .O4        (O4),
        .O5        (O5),
        .O6        (O6),
        .O7        (O7),
        .lane_vld  (lane_vld),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [8*W-1:0] dut_bundle();
        return {O7, O6, O5, O4, O3, O2, O1, O0};
    endfunction

    function automatic logic [8*W-1:0] model_bundle();
        return {m_o[7], m_o[6], m_o[5], m_o[4], m_o[3], m_o[2], m_o[1], m_o[0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_o[k] = '0;
        m_vld  = '0;
        m_ptr  = '0;
        m_mode = 1'b0;
    endtask

    // One accepted write; model mirrors the lane map 7-F or the sequential pointer.
    task automatic wr(input logic m, input logic [2:0] f, input logic [W-1:0] d);
        int lane;
        mode = m; F = f; D = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (m_vld == 8'h00) m_mode = m;
        lane = m_mode ? int'(m_ptr) : 7 - int'(f);
        m_o[lane] = d;
        m_vld[lane] = 1'b1;
        if (m_mode) m_ptr = m_ptr + 3'd1;
        if (m_vld == 8'hFF) sb_q.push_back(model_bundle());
    endtask

    // Wait (bounded) for a bundle, compare it against the scoreboard, then accept it.
    task automatic take_bundle();
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        check("hs_out_valid", 64'(out_valid), 64'd1);
        check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) check("sb_bundle", 64'(dut_bundle()), 64'(sb_q.pop_front()));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        m_vld = '0;
        m_ptr = '0;
        check("hs_lane_vld", 64'(lane_vld), 64'h00);
        check("hs_in_ready", 64'(in_ready), 64'd1);
        check("hs_out_valid_low", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [8*W-1:0] held;
        model_reset();

        // 1: reset with in_valid high
        in_valid = 1'b1; D = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bundle", 64'(dut_bundle()), 64'h0);
        check("rst_lane_vld", 64'(lane_vld), 64'h00);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: addressed map, F=7..0 with D=F+1
        for (int f = 7; f >= 0; f--) begin
            wr(1'b0, 3'(f), W'(f + 1));
            if (f == 1) check("addr_not_full", 64'(out_valid), 64'd0);
        end
        check("addr_o0", 64'(O0), 64'd8);
        check("addr_o7", 64'(O7), 64'd1);
        check("addr_out_valid", 64'(out_valid), 64'd1);
        check("addr_in_ready", 64'(in_ready), 64'd0);
        take_bundle();

        // 3: sequential; mode drops after the first write and must be ignored
        for (int i = 0; i < 8; i++) begin
            wr((i == 0) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)), W'(8'hA0 + i));
            if (i == 3) check("seq_vld_half", 64'(lane_vld), 64'h0F);
        end
        check("seq_bundle", 64'(dut_bundle()), 64'hA7A6A5A4A3A2A1A0);
        check("seq_out_valid", 64'(out_valid), 64'd1);

        // 4: back-pressure in FULL with in_valid held high
        held = dut_bundle();
        in_valid = 1'b1; D = 8'hFF; mode = 1'b0; F = 3'd7;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_bundle", 64'(dut_bundle()), 64'(held));
        check("bp_lane_vld", 64'(lane_vld), 64'hFF);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        take_bundle();

        // 5: addressed overwrite of lane 0
        wr(1'b0, 3'd7, 8'd3);
        wr(1'b0, 3'd7, 8'd5);
        check("ow_o0", 64'(O0), 64'd5);
        check("ow_lane_vld", 64'(lane_vld), 64'h01);
        check("ow_fill", 64'({in_ready, out_valid}), 64'b10);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_vld = '0; m_ptr = '0;
        check("ow_clear_vld", 64'(lane_vld), 64'h00);

        // 6a: clear mid-fill drops the simultaneous write
        wr(1'b1, 3'd0, 8'h11);
        wr(1'b1, 3'd0, 8'h22);
        wr(1'b1, 3'd0, 8'h33);
        check("fl_vld3", 64'(lane_vld), 64'h07);
        clear = 1'b1; in_valid = 1'b1; D = 8'h44; mode = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        m_vld = '0; m_ptr = '0;
        check("fl_clear_vld", 64'(lane_vld), 64'h00);
        check("fl_dropped", 64'(dut_bundle()), 64'(model_bundle()));
        wr(1'b1, 3'd5, 8'h55);
        check("fl_next_o0", 64'(O0), 64'h55);
        check("fl_next_vld", 64'(lane_vld), 64'h01);

        // 6b: reset mid-fill discards everything
        wr(1'b1, 3'd0, 8'h66);
        wr(1'b1, 3'd0, 8'h77);
        check("rf_bundle", 64'(dut_bundle()), 64'(model_bundle()));
        rst_n = 1'b0; in_valid = 1'b1; D = 8'h88;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        model_reset();
        check("rf_rst_bundle", 64'(dut_bundle()), 64'h0);
        check("rf_rst_vld", 64'(lane_vld), 64'h00);
        wr(1'b1, 3'd3, 8'h99);
        check("rf_next_o0", 64'(O0), 64'h99);
        check("rf_next_bundle", 64'(dut_bundle()), 64'(model_bundle()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
